uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit FIFO write port (tx_wr / tx_wr_data) between NUM_REQ independent byte-stream requesters.
- Arbitration is round-robin at packet granularity. A granted requester owns the port until its last byte is accepted or the MAX_BURST limit is hit.
- Sits between on-chip message sources and the transmit FIFO write side of the UART top. Honours the FIFO full flag so that no byte is ever dropped.

---
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmit-FIFO-side signals of the UART transmit arbiter.
// The arbiter connects through the slave modport; the surrounding logic drives through master.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            grant;
    logic                          tx_full;
    logic                          tx_wr;
    logic [DATA_WIDTH-1:0]         tx_wr_data;
    logic                          busy;
    logic                          burst_err;

    modport master (
        output req, req_data, req_last, tx_full,
        input  req_ack, grant, tx_wr, tx_wr_data, busy, burst_err
    );

    modport slave (
        input  req, req_data, req_last, tx_full,
        output req_ack, grant, tx_wr, tx_wr_data, busy, burst_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmit FIFO write port
// among NUM_REQ byte-stream requesters, with a MAX_BURST forced-release limit.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic              clk,
    input  logic              rstN,
    uart_tx_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               burst_err_q, burst_err_d;

    logic                  found;
    logic [IDX_W-1:0]      winner;
    logic                  accept;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!found && bus.req[IDX_W'(idx)]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    assign accept = (state_q == XFER) && bus.req[g_q] && !bus.tx_full;

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        grant_d      = grant_q;
        burst_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = XFER;
                    g_d     = winner;
                    grant_d = NUM_REQ'(1) << winner;
                    count_d = '0;
                end
            end
            XFER: begin
                if (accept) begin
                    if (bus.req_last[g_q] || (count_q == CNT_W'(MAX_BURST - 1))) begin
                        state_d      = IDLE;
                        last_grant_d = g_q;
                        grant_d      = '0;
                        count_d      = '0;
                        burst_err_d  = !bus.req_last[g_q];
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q      <= IDLE;
            g_q          <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            count_q      <= '0;
            grant_q      <= '0;
            burst_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            grant_q      <= grant_d;
            burst_err_q  <= burst_err_d;
        end
    end

    // grant_q is already onehot(g_q) while transferring, so it doubles as the ack mask.
    assign bus.req_ack    = accept ? grant_q : '0;
    assign bus.tx_wr      = accept;
    assign bus.tx_wr_data = accept ? data_arr[g_q] : '0;
    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q == XFER);
    assign bus.burst_err  = burst_err_q;

    a_no_wr_when_full: assert property (@(posedge clk) disable iff (!rstN)
        !(bus.tx_wr && bus.tx_full));
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rstN)
        $onehot0(bus.grant));
    a_ack_onehot: assert property (@(posedge clk) disable iff (!rstN)
        $onehot0(bus.req_ack));
    a_ack_subset: assert property (@(posedge clk) disable iff (!rstN)
        ((bus.req_ack & ~bus.grant) == '0));
    a_busy_grant: assert property (@(posedge clk) disable iff (!rstN)
        (bus.busy == (bus.grant != '0)));
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed vector bench for uart_tx_arbiter (4 requesters, MAX_BURST=4):
// each record is one clock cycle of inputs plus the outputs expected in that cycle.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ   (4),
        .DATA_WIDTH(8),
        .MAX_BURST (4)
    ) dut (
        .clk (clk),
        .rstN(rst_n),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic [3:0]  e_grant;
        logic [3:0]  e_ack;
        logic        e_wr;
        logic [7:0]  e_data;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input string n, input logic r, input logic [3:0] rq,
                                input logic [31:0] d, input logic [3:0] l, input logic f,
                                input logic [3:0] eg, input logic [3:0] ea, input logic ew,
                                input logic [7:0] ed, input logic eb, input logic ee);
        vec_t v;
        v.name = n; v.rst_n = r; v.req = rq; v.data = d; v.last = l; v.full = f;
        v.e_grant = eg; v.e_ack = ea; v.e_wr = ew; v.e_data = ed; v.e_busy = eb; v.e_err = ee;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst_n        = v.rst_n;
        bus.req      = v.req;
        bus.req_data = v.data;
        bus.req_last = v.last;
        bus.tx_full  = v.full;
        #1;
        n_vec++;
        if (bus.grant !== v.e_grant || bus.req_ack !== v.e_ack || bus.tx_wr !== v.e_wr ||
            bus.tx_wr_data !== v.e_data || bus.busy !== v.e_busy || bus.burst_err !== v.e_err) begin
            n_bad++;
            $display("FAIL %s: got grant=%b ack=%b wr=%b data=%02h busy=%b err=%b, want grant=%b ack=%b wr=%b data=%02h busy=%b err=%b",
                     v.name, bus.grant, bus.req_ack, bus.tx_wr, bus.tx_wr_data, bus.busy, bus.burst_err,
                     v.e_grant, v.e_ack, v.e_wr, v.e_data, v.e_busy, v.e_err);
        end else begin
            $display("vec %0d %s: grant=%b ack=%b wr=%b data=%02h busy=%b err=%b ok",
                     n_vec, v.name, bus.grant, bus.req_ack, bus.tx_wr, bus.tx_wr_data,
                     bus.busy, bus.burst_err);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        bus.tx_full  = 1'b0;

        // Reset for three edges with all requesters asking, then 1-byte round-robin packets.
        tbl.push_back(mk("rst0",        0, 4'b1111, 32'h13121110, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(mk("rst1",        0, 4'b1111, 32'h13121110, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(mk("idle_release",1, 4'b1111, 32'h13121110, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(mk("rr_r0",       1, 4'b1111, 32'h13121110, 4'b1111, 0, 4'b0001, 4'b0001, 1, 8'h10, 1, 0));
        tbl.push_back(mk("rr_gap0",     1, 4'b1111, 32'h13121110, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(mk("rr_r1",       1, 4'b1111, 32'h13121110, 4'b1111, 0, 4'b0010, 4'b0010, 1, 8'h11, 1, 0));
        tbl.push_back(mk("rr_gap1",     1, 4'b1111, 32'h13121110, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(mk("rr_r2",       1, 4'b1111, 32'h13121110, 4'b1111, 0, 4'b0100, 4'b0100, 1, 8'h12, 1, 0));
        tbl.push_back(mk("rr_gap2",     1, 4'b1111, 32'h13121110, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(mk("rr_r3",       1, 4'b1111, 32'h13121110, 4'b1111, 0, 4'b1000, 4'b1000, 1, 8'h13, 1, 0));
        tbl.push_back(mk("rr_gap3",     1, 4'b1111, 32'h13121110, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(mk("rr_r0_again", 1, 4'b1111, 32'h13121110, 4'b1111, 0, 4'b0001, 4'b0001, 1, 8'h10, 1, 0));
        // Requester 2 sends a three-byte packet.
        tbl.push_back(mk("pkt_idle",    1, 4'b0100, 32'h00A10000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(mk("pkt_a1",      1, 4'b0100, 32'h00A10000, 4'b0000, 0, 4'b0100, 4'b0100, 1, 8'hA1, 1, 0));
        tbl.push_back(mk("pkt_a2",      1, 4'b0100, 32'h00A20000, 4'b0000, 0, 4'b0100, 4'b0100, 1, 8'hA2, 1, 0));
        tbl.push_back(mk("pkt_a3",      1, 4'b0100, 32'h00A30000, 4'b0100, 0, 4'b0100, 4'b0100, 1, 8'hA3, 1, 0));
        tbl.push_back(mk("pkt_done",    1, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        // Requester 1 under backpressure: FIFO full for five cycles after the first byte.
        tbl.push_back(mk("bp_idle",     1, 4'b0010, 32'h00005500, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(mk("bp_55",       1, 4'b0010, 32'h00005500, 4'b0000, 0, 4'b0010, 4'b0010, 1, 8'h55, 1, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk($sformatf("bp_full%0d", i), 1, 4'b0010, 32'h00006600, 4'b0010, 1,
                             4'b0010, 4'b0000, 0, 8'h00, 1, 0));
        tbl.push_back(mk("bp_66",       1, 4'b0010, 32'h00006600, 4'b0010, 0, 4'b0010, 4'b0010, 1, 8'h66, 1, 0));
        tbl.push_back(mk("bp_done",     1, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        // Requester 0 streams six bytes without last; requester 3 waits with a 1-byte packet.
        tbl.push_back(mk("fr_idle",     1, 4'b0001, 32'h000000B0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(mk("fr_b0",       1, 4'b1001, 32'h300000B0, 4'b1000, 0, 4'b0001, 4'b0001, 1, 8'hB0, 1, 0));
        tbl.push_back(mk("fr_b1",       1, 4'b1001, 32'h300000B1, 4'b1000, 0, 4'b0001, 4'b0001, 1, 8'hB1, 1, 0));
        tbl.push_back(mk("fr_b2",       1, 4'b1001, 32'h300000B2, 4'b1000, 0, 4'b0001, 4'b0001, 1, 8'hB2, 1, 0));
        tbl.push_back(mk("fr_b3",       1, 4'b1001, 32'h300000B3, 4'b1000, 0, 4'b0001, 4'b0001, 1, 8'hB3, 1, 0));
        tbl.push_back(mk("fr_release",  1, 4'b1001, 32'h300000B4, 4'b1000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        tbl.push_back(mk("fr_r3",       1, 4'b1001, 32'h300000B4, 4'b1000, 0, 4'b1000, 4'b1000, 1, 8'h30, 1, 0));
        tbl.push_back(mk("fr_gap",      1, 4'b0001, 32'h000000B4, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(mk("fr_b4",       1, 4'b0001, 32'h000000B4, 4'b0000, 0, 4'b0001, 4'b0001, 1, 8'hB4, 1, 0));
        tbl.push_back(mk("fr_b5",       1, 4'b0001, 32'h000000B5, 4'b0001, 0, 4'b0001, 4'b0001, 1, 8'hB5, 1, 0));
        tbl.push_back(mk("fr_done",     1, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));

        @(posedge clk);
        foreach (tbl[i]) apply(tbl[i]);

        // Stall: requester 0 drops req mid-packet while requester 1 waits; grant must be held.
        apply(mk("st_idle", 1, 4'b0001, 32'h000000C0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        apply(mk("st_c0",   1, 4'b0001, 32'h000000C0, 4'b0000, 0, 4'b0001, 4'b0001, 1, 8'hC0, 1, 0));
        for (int i = 0; i < 3; i++)
            apply(mk($sformatf("st_hold%0d", i), 1, 4'b0010, 32'h0000D100, 4'b0010, 0,
                     4'b0001, 4'b0000, 0, 8'h00, 1, 0));
        apply(mk("st_c1",   1, 4'b0011, 32'h0000D1C1, 4'b0010, 0, 4'b0001, 4'b0001, 1, 8'hC1, 1, 0));

        // One-cycle reset mid-packet abandons it; requester 0 wins again afterwards.
        apply(mk("mr_rst",  0, 4'b0010, 32'h0000D1C2, 4'b0010, 0, 4'b0001, 4'b0000, 0, 8'h00, 1, 0));
        apply(mk("mr_idle", 1, 4'b0011, 32'h0000D1C0, 4'b0011, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        apply(mk("mr_c0",   1, 4'b0011, 32'h0000D1C0, 4'b0011, 0, 4'b0001, 4'b0001, 1, 8'hC0, 1, 0));
        apply(mk("mr_gap",  1, 4'b0010, 32'h0000D100, 4'b0010, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        apply(mk("mr_d1",   1, 4'b0010, 32'h0000D100, 4'b0010, 0, 4'b0010, 4'b0010, 1, 8'hD1, 1, 0));
        apply(mk("mr_done", 1, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
